uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single serial transmitter among `N_REQ` byte producers. Each requester offers a byte with a valid/ready handshake; the arbiter picks one round-robin, issues a one-cycle write strobe and data byte to the transmitter, and holds off further grants until the transmitter's busy cycle completes. It sits between the producers (status reporters, debug dump, echo path) and the serial transmitter in the serial top level.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 8, byte width passed to transmitter

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  N_REQ  requester i has a byte
- `req_data`  in  N_REQ*DATA_W  flat; requester i at bits [i*DATA_W +: DATA_W]
- `req_ready`  out  N_REQ  one-hot pulse: byte of requester i accepted this cycle
- `req_lock`  in  N_REQ  requester i asks to keep grant for next byte (only under `UART_ARB_LOCK_EN`)
- `tx_we`  out  1  one-cycle write strobe to transmitter
- `tx_data`  out  DATA_W  byte to transmitter, stable from strobe until next acceptance
- `tx_busy`  in  1  transmitter shifting a frame
- `grant_id`  out  $clog2(N_REQ)  index of last accepted requester
- `arb_busy`  out  1  arbiter not in IDLE

## Operation
- FSM states: IDLE, SEND, WAIT_START, WAIT_DONE.
- IDLE: if any `req_valid` and `tx_busy`=0, select winner w = first valid index at or after `rr_ptr`, wrapping modulo N_REQ. Same cycle: `req_ready[w]`=1 (combinational from state/valid/ptr), `tx_data` <= req_data[w], `grant_id` <= w, `rr_ptr` <= (w+1) mod N_REQ, go SEND. If `tx_busy`=1 in IDLE, no grant.
- SEND: `tx_we`=1 for exactly this cycle; go WAIT_START.
- WAIT_START: stay until `tx_busy`=1, then WAIT_DONE. (No timeout; transmitter contract requires busy within bounded cycles.)
- WAIT_DONE: stay while `tx_busy`=1; on `tx_busy`=0 go IDLE.
- `req_ready` is 0 in all states except IDLE; at most one bit high.
- Requesters must hold `req_valid`/`req_data` until `req_ready`; dropping valid before acceptance is legal and simply withdraws the request.
- `arb_busy` = (state != IDLE).

## Timing
- Reset values: `tx_we`=0, `tx_data`=0, `req_ready`=0, `grant_id`=0, `arb_busy`=0, `rr_ptr`=0, state IDLE.
- Latency: acceptance in cycle A (IDLE), `tx_we` in cycle A+1; `tx_data` valid from A+1.
- Back-to-back: next acceptance earliest in the first IDLE cycle after `tx_busy` falls (one cycle after it is seen low in WAIT_DONE).
- Wrap: with `rr_ptr`=N_REQ-1 and only requester 0 valid, grant 0, `rr_ptr` -> 1.
- Simultaneous valids: lowest index at or after `rr_ptr` wins; others keep waiting.
- Reset mid-operation (any state): returns to IDLE next cycle, all outputs to reset values; an in-flight transmitter frame is not aborted by this block.

## Configuration
- `UART_ARB_LOCK_EN` defined: at acceptance, if `req_lock[w]`=1, set `lock_valid` and `lock_id`=w; in next IDLE, if `req_valid[lock_id]`=1 it wins regardless of `rr_ptr`, else lock clears and normal round-robin applies. `rr_ptr` still updates to w+1 on each locked grant. Lock cleared by reset.
- Not defined: `req_lock` port absent, pure round-robin.

## Structure
- Shared package `uart_pkg`: FSM state enum (`arb_state_t`), `UART_DATA_W`=8 constant.
- One sub-module natural: `rr_pick` (combinational: valid vector + pointer -> one-hot winner + index + any-valid).

## Test plan
- Reset: hold `rst`=1 two cycles with all valids high -> `req_ready`=0, `tx_we`=0, `tx_data`=0x00 throughout.
- Single request: req 2 valid with 0x2A, transmitter model busy 10 cycles -> `req_ready`=4'b0100 for one cycle, `tx_we` next cycle with `tx_data`=0x2A, next grant only after busy falls.
- Fairness: all four valid continuously with 0x10..0x13 -> grant order 0,1,2,3,0 and bytes 0x10,0x11,0x12,0x13,0x10 on strobes.
- Wrap/skip: `rr_ptr`=3, only req 0 and 1 valid -> grant 0 then 1.
- Busy gating: `tx_busy`=1 while in IDLE with req 1 valid -> no `req_ready` until `tx_busy`=0.
- Lock (macro on): req 1 valid+lock with 3 bytes, req 0 valid -> req 1 granted 3 consecutive times, then req 0; reset mid-WAIT_DONE -> IDLE, lock cleared, `arb_busy`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the serial transmit path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_START,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr_i, wrapping.
module rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] hiMask;
  logic [N-1:0] hiValid;
  logic [N-1:0] cand;
  logic [N-1:0] oneHot;

  // Prefer requesters at or above the pointer; if none, wrap to the lowest valid.
  always_comb begin
    hiMask  = ~((ONE << ptr_i) - ONE);
    hiValid = valid_i & hiMask;
    cand    = (|hiValid) ? hiValid : valid_i;
    oneHot  = cand & (~cand + ONE);
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (oneHot[i]) begin
        idx_o = IDX_W'(i);
      end
    end
    onehot_o = oneHot;
    any_o    = |valid_i;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among N_REQ byte producers.
// Optional grant locking is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = UART_DATA_W,
  localparam int IDX_W  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
`ifdef UART_ARB_LOCK_EN
  input  logic [N_REQ-1:0]          req_lock,
`endif
  output logic                      tx_we,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      arb_busy
);

  arb_state_t        state_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  rr_ptr_d;
  logic              tx_we_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [DATA_W-1:0] tx_data_d;
  logic [IDX_W-1:0]  grant_id_q;
  logic              arb_busy_q;

  logic [IDX_W-1:0]  pickPtr;
  logic [N_REQ-1:0]  pickOneHot;
  logic [IDX_W-1:0]  pickIdx;
  logic              pickAny;
  logic              grant;

`ifdef UART_ARB_LOCK_EN
  logic              lock_valid_q;
  logic [IDX_W-1:0]  lock_id_q;

  // A held lock steers the picker straight at its owner while the owner still has data.
  assign pickPtr = (lock_valid_q && req_valid[lock_id_q]) ? lock_id_q : rr_ptr_q;
`else
  assign pickPtr = rr_ptr_q;
`endif

  rr_pick #(
    .N(N_REQ)
  ) u_rr_pick (
    .valid_i  (req_valid),
    .ptr_i    (pickPtr),
    .onehot_o (pickOneHot),
    .idx_o    (pickIdx),
    .any_o    (pickAny)
  );

  assign grant     = !rst && (state_q == IDLE) && !tx_busy && pickAny;
  assign req_ready = grant ? pickOneHot : '0;
  assign rr_ptr_d  = (pickIdx == IDX_W'(N_REQ - 1)) ? '0 : pickIdx + IDX_W'(1);

  always_comb begin
    tx_data_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pickOneHot[i]) begin
        tx_data_d = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Reset does not abort a frame already handed to the transmitter; it only returns here to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      tx_we_q      <= 1'b0;
      tx_data_q    <= '0;
      grant_id_q   <= '0;
      arb_busy_q   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_valid_q <= 1'b0;
      lock_id_q    <= '0;
`endif
    end else begin
      tx_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_q    <= SEND;
            tx_we_q    <= 1'b1;
            tx_data_q  <= tx_data_d;
            grant_id_q <= pickIdx;
            rr_ptr_q   <= rr_ptr_d;
            arb_busy_q <= 1'b1;
`ifdef UART_ARB_LOCK_EN
            lock_valid_q <= req_lock[pickIdx];
            lock_id_q    <= pickIdx;
          end else if (lock_valid_q && !req_valid[lock_id_q]) begin
            lock_valid_q <= 1'b0;
`endif
          end
        end
        SEND: begin
          state_q <= WAIT_START;
        end
        WAIT_START: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state_q    <= IDLE;
            arb_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          arb_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_we    = tx_we_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign arb_busy = arb_busy_q;

endmodule
